// File: rtl/spi_shift_unit_if.sv
// spi_shift_unit_if: bundle between the SPI control machine / register block and the shift unit.
// master drives wlen, cs_n, shift_on, shift_out_load, dr_load, write_en, sread, dread, tx_data,
// sio0_in, sio1_in, rx_ack (and lsb_first when SPI_LSB_FIRST_EN is defined).
// slave drives tx_req, sio_out, sio_oe, rx_data, rx_valid, rx_ovr.
interface spi_shift_unit_if #(parameter int DW = 32);
  logic [4:0] wlen;
  logic cs_n, shift_on, shift_out_load, dr_load, write_en, sread, dread;
  logic sio0_in, sio1_in, rx_ack;
  logic [DW-1:0] tx_data, rx_data;
  logic tx_req, sio_out, sio_oe, rx_valid, rx_ovr;
`ifdef SPI_LSB_FIRST_EN
  logic lsb_first;
`endif
  modport master(
    output wlen, cs_n, shift_on, shift_out_load, dr_load, write_en, sread, dread,
    output tx_data, sio0_in, sio1_in, rx_ack,
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    input tx_req, sio_out, sio_oe, rx_data, rx_valid, rx_ovr
  );
  modport slave(
    input wlen, cs_n, shift_on, shift_out_load, dr_load, write_en, sread, dread,
    input tx_data, sio0_in, sio1_in, rx_ack,
`ifdef SPI_LSB_FIRST_EN
    input lsb_first,
`endif
    output tx_req, sio_out, sio_oe, rx_data, rx_valid, rx_ovr
  );
endinterface

// File: rtl/spi_shift_unit.sv
// spi_shift_unit: SPI serial datapath - serialises TX words onto SIO0 and deserialises RX bits
// (single-wire, 2-wire or dual) into right-aligned words for the register block.
// Ports: clk, rst_n (async active-low), bus (spi_shift_unit_if.slave: control strobes, tx_data,
// pad inputs, rx_ack in; tx_req, sio_out, sio_oe, rx_data, rx_valid, rx_ovr out).
// Optional feature: define SPI_LSB_FIRST_EN to add bus.lsb_first (LSB-first TX and RX).
module spi_shift_unit #(
  parameter int   DW       = 32,
  parameter logic IDLE_OUT = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  spi_shift_unit_if.slave bus
);
  logic [DW-1:0] txsr_q, txsr_d, rxsr_q, rxsr_d, rx_data_q, rx_data_d;
  logic [DW-1:0] tx_mask, rx_mask, tx_rev, rx_rev, tx_word, rx_src, rx_word;
  logic [4:0] wlen_rx;
  logic sio_out_q, sio_out_d, sio_oe_q, sio_oe_d, tx_req_q, tx_req_d, cap_v_q, cap_v_d;
  logic rx_valid_q, rx_valid_d, rx_pending_q, rx_pending_d, rx_ovr_q, rx_ovr_d;
  logic lsb, pair_hi, pair_lo, tx_shift;
`ifdef SPI_LSB_FIRST_EN
  assign lsb = bus.lsb_first;
`else
  assign lsb = 1'b0;
`endif
  // Dual mode always commits an even number of bits.
  assign wlen_rx  = bus.dread ? {bus.wlen[4:1], 1'b1} : bus.wlen;
  assign tx_mask  = {DW{1'b1}} >> (5'd31 - bus.wlen);
  assign rx_mask  = {DW{1'b1}} >> (5'd31 - wlen_rx);
  assign tx_rev   = {<<{bus.tx_data & tx_mask}};
  assign tx_word  = lsb ? tx_rev : bus.tx_data << (5'd31 - bus.wlen);
  assign tx_shift = bus.shift_on & bus.write_en;
  assign {pair_hi, pair_lo} = lsb ? {bus.sio0_in, bus.sio1_in} : {bus.sio1_in, bus.sio0_in};
  // Commit sees this cycle's capture, since dr_load coincides with the last cap_v.
  assign rx_src = !cap_v_q ? rxsr_q :
                  bus.dread ? {rxsr_q[DW-3:0], pair_hi, pair_lo} :
                  {rxsr_q[DW-2:0], bus.sread ? bus.sio0_in : bus.sio1_in};
  assign rx_rev       = {<<{rx_src & rx_mask}};
  assign rx_word      = lsb ? rx_rev >> (5'd31 - wlen_rx) : rx_src & rx_mask;
  assign txsr_d       = bus.shift_out_load ? tx_word : tx_shift ? txsr_q << 1 : txsr_q;
  assign rxsr_d       = bus.shift_out_load ? '0 : rx_src;
  assign sio_out_d    = tx_shift ? txsr_q[DW-1] : IDLE_OUT;
  assign sio_oe_d     = ~bus.cs_n & ~bus.sread & ~bus.dread;
  assign tx_req_d     = bus.shift_out_load;
  // Pads are sampled a cycle after shift_on; a deasserted cs_n kills the capture.
  assign cap_v_d      = bus.shift_on & ~bus.cs_n;
  assign rx_data_d    = bus.dr_load ? rx_word : rx_data_q;
  assign rx_valid_d   = bus.dr_load;
  // A same-cycle ack lets the new word in without flagging overrun.
  assign rx_pending_d = bus.dr_load | (rx_pending_q & ~bus.rx_ack);
  assign rx_ovr_d     = ~bus.rx_ack & (rx_ovr_q | (bus.dr_load & rx_pending_q));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      txsr_q       <= '0;
      rxsr_q       <= '0;
      rx_data_q    <= '0;
      sio_out_q    <= IDLE_OUT;
      sio_oe_q     <= 1'b0;
      tx_req_q     <= 1'b0;
      cap_v_q      <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_pending_q <= 1'b0;
      rx_ovr_q     <= 1'b0;
    end else begin
      txsr_q       <= txsr_d;
      rxsr_q       <= rxsr_d;
      rx_data_q    <= rx_data_d;
      sio_out_q    <= sio_out_d;
      sio_oe_q     <= sio_oe_d;
      tx_req_q     <= tx_req_d;
      cap_v_q      <= cap_v_d;
      rx_valid_q   <= rx_valid_d;
      rx_pending_q <= rx_pending_d;
      rx_ovr_q     <= rx_ovr_d;
    end
  assign bus.tx_req   = tx_req_q;
  assign bus.sio_out  = sio_out_q;
  assign bus.sio_oe   = sio_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_ovr   = rx_ovr_q;
endmodule

// File: tb/tb_spi_shift_unit.sv
// tb_spi_shift_unit: directed stimulus with a bit-queue reference model and literal pins.
module tb_spi_shift_unit;
  localparam logic IDLE = 1'b0;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_shift_unit_if #(.DW(32)) bus();
  spi_shift_unit #(.DW(32), .IDLE_OUT(IDLE)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0;
  int txreq_cnt = 0, rxv_cnt = 0, tx_cnt = 0;
  logic [31:0] tx_seq = '0, last_rx = '0;
  logic ack_at_load = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic lsb();
`ifdef SPI_LSB_FIRST_EN
    return bus.lsb_first;
`else
    return 1'b0;
`endif
  endfunction
  // Reference model: TX word as a queue of bits in send order, RX as a queue of captured bits.
  logic tx_q[$];
  logic rx_q[$];
  logic m_sio_out, m_oe, m_tx_req, m_rx_valid, m_ovr, m_pending, m_cap, m_shifted;
  logic [31:0] m_rx_data;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      m_sio_out <= IDLE; m_oe <= 1'b0; m_tx_req <= 1'b0; m_rx_valid <= 1'b0;
      m_ovr <= 1'b0; m_pending <= 1'b0; m_cap <= 1'b0; m_shifted <= 1'b0; m_rx_data <= '0;
    end else begin
      logic bit_out, hi, lo;
      logic [31:0] v, r;
      int n;
      bit_out = IDLE;
      if (bus.shift_on && bus.write_en) bit_out = tx_q.size() > 0 ? tx_q.pop_front() : 1'b0;
      m_sio_out <= bit_out;
      m_shifted <= bus.shift_on && bus.write_en;
      if (bus.shift_out_load) begin
        tx_q.delete();
        for (int i = 0; i <= int'(bus.wlen); i++)
          tx_q.push_back(lsb() ? bus.tx_data[i] : bus.tx_data[int'(bus.wlen) - i]);
      end
      m_oe <= !bus.cs_n && !bus.sread && !bus.dread;
      m_tx_req <= bus.shift_out_load;
      if (m_cap) begin
        if (bus.dread) begin
          hi = lsb() ? bus.sio0_in : bus.sio1_in;
          lo = lsb() ? bus.sio1_in : bus.sio0_in;
          rx_q.push_back(hi);
          rx_q.push_back(lo);
        end else rx_q.push_back(bus.sread ? bus.sio0_in : bus.sio1_in);
      end
      m_cap <= bus.shift_on && !bus.cs_n;
      m_rx_valid <= bus.dr_load;
      if (bus.dr_load) begin
        n = (bus.dread ? (int'(bus.wlen) | 1) : int'(bus.wlen)) + 1;
        v = '0;
        for (int i = (rx_q.size() > n ? rx_q.size() - n : 0); i < rx_q.size(); i++) v = {v[30:0], rx_q[i]};
        r = '0;
        for (int i = 0; i < n; i++) r[i] = v[n - 1 - i];
        m_rx_data <= lsb() ? r : v;
        if (m_pending && !bus.rx_ack) m_ovr <= 1'b1;
        else if (bus.rx_ack) m_ovr <= 1'b0;
        m_pending <= 1'b1;
      end else if (bus.rx_ack) begin
        m_pending <= 1'b0;
        m_ovr <= 1'b0;
      end
      if (bus.shift_out_load) rx_q.delete();
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("sio_out", bus.sio_out, m_sio_out);
      chk("sio_oe", bus.sio_oe, m_oe);
      chk("tx_req", bus.tx_req, m_tx_req);
      chk("rx_valid", bus.rx_valid, m_rx_valid);
      chk("rx_data", bus.rx_data, m_rx_data);
      chk("rx_ovr", bus.rx_ovr, m_ovr);
      if (m_shifted) begin
        tx_seq = {tx_seq[30:0], bus.sio_out};
        tx_cnt++;
      end
      if (bus.tx_req) txreq_cnt++;
      if (bus.rx_valid) begin
        rxv_cnt++;
        last_rx = bus.rx_data;
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ack();
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
  endtask
  // One word: load, shift_on per bit (or pair), pads for shift k driven the cycle after it,
  // dr_load one cycle after the last shift_on. abort>0 raises cs_n after that many shifts.
  task automatic word(input logic [4:0] w, input logic we, input logic sr, input logic dr,
                      input logic [31:0] tx, input logic [31:0] rx, input int abort);
    int nb, ns;
    logic b;
    bus.wlen = w; bus.write_en = we; bus.sread = sr; bus.dread = dr;
    bus.cs_n = 1'b0; bus.tx_data = tx;
    bus.shift_out_load = 1'b1;
    tick();
    bus.shift_out_load = 1'b0;
    nb = dr ? (int'(w) | 1) + 1 : int'(w) + 1;
    ns = abort > 0 ? abort : dr ? nb / 2 : nb;
    for (int j = 0; j <= ns; j++) begin
      bus.shift_on = j < ns;
      if (j > 0) begin
        if (dr) begin
          bus.sio1_in = rx[nb - 2 * j + 1];
          bus.sio0_in = rx[nb - 2 * j];
        end else begin
          b = rx[nb - j];
          bus.sio0_in = sr ? b : ~b;
          bus.sio1_in = sr ? ~b : b;
        end
      end
      bus.dr_load = (j == ns) && abort == 0;
      bus.rx_ack = (j == ns) && ack_at_load;
      if (j == ns && abort > 0) bus.cs_n = 1'b1;
      tick();
    end
    bus.shift_on = 1'b0; bus.dr_load = 1'b0; bus.rx_ack = 1'b0;
  endtask
  initial begin
    int c0;
    bus.wlen = 5'd7; bus.cs_n = 1'b1; bus.shift_on = 1'b0; bus.shift_out_load = 1'b0;
    bus.dr_load = 1'b0; bus.write_en = 1'b0; bus.sread = 1'b0; bus.dread = 1'b0;
    bus.tx_data = '0; bus.sio0_in = 1'b0; bus.sio1_in = 1'b0; bus.rx_ack = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    #12;
    chk("rst_tx_req", bus.tx_req, 1'b0);
    chk("rst_sio_out", bus.sio_out, IDLE);
    chk("rst_sio_oe", bus.sio_oe, 1'b0);
    chk("rst_rx_data", bus.rx_data, 32'h0);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_rx_ovr", bus.rx_ovr, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    word(5'd7, 1'b1, 1'b0, 1'b0, 32'hA5, 32'h0, 0);
    tick();
    chk("t1_tx_seq", tx_seq[7:0], 8'hA5);
    chk("t1_tx_cnt", tx_cnt, 8);
    chk("t1_tx_req_cnt", txreq_cnt, 1);
    ack();
    c0 = rxv_cnt;
    word(5'd7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3C, 0);
    chk("t2_sio_oe", bus.sio_oe, 1'b1);
    chk("t2_sio_out", bus.sio_out, IDLE);
    tick();
    chk("t2_rx_data", last_rx, 32'h3C);
    chk("t2_rx_valid_cnt", rxv_cnt - c0, 1);
    ack();
    word(5'd15, 1'b0, 1'b0, 1'b1, 32'h0, 32'hBEEF, 0);
    chk("t3_sio_oe", bus.sio_oe, 1'b0);
    tick();
    chk("t3_rx_data", last_rx, 32'hBEEF);
    ack();
    word(5'd7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h11, 0);
    word(5'd7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h22, 0);
    tick();
    chk("t4_ovr_set", bus.rx_ovr, 1'b1);
    chk("t4_rx_second", last_rx, 32'h22);
    ack();
    chk("t4_ovr_clr", bus.rx_ovr, 1'b0);
    word(5'd7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h33, 0);
    ack_at_load = 1'b1;
    word(5'd7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44, 0);
    ack_at_load = 1'b0;
    tick();
    chk("t4_ack_coinc_ovr", bus.rx_ovr, 1'b0);
    chk("t4_ack_coinc_rx", last_rx, 32'h44);
    ack();
    c0 = rxv_cnt;
    word(5'd31, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC3A5_F00F, 10);
    repeat (3) tick();
    chk("t5_no_valid", rxv_cnt - c0, 0);
    chk("t5_oe_low", bus.sio_oe, 1'b0);
    word(5'd7, 1'b0, 1'b1, 1'b0, 32'h0, 32'h5A, 0);
    tick();
    chk("t5_rx_data", last_rx, 32'h5A);
    chk("t5_valid_cnt", rxv_cnt - c0, 1);
    ack();
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b1;
    tx_seq = '0;
    tx_cnt = 0;
    word(5'd7, 1'b1, 1'b0, 1'b0, 32'h01, 32'h80, 0);
    tick();
    chk("t6_tx_seq", tx_seq[7:0], 8'h80);
    chk("t6_rx_data", last_rx, 32'h01);
    ack();
    bus.lsb_first = 1'b0;
`endif
    bus.cs_n = 1'b1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
